spi_cmd_ctrl: RTL and testbench

- Command controller behind the 16-bit SPI slave datapath.
- Decodes received SPI words into register read/write commands.
- Holds the accelerator configuration/control registers and sequences read responses back into the slave's transmit shift register.
- Sits between the SPI slave's bus master/slave ports and the accelerator core.

---
 rtl/spi_ctrl_pkg.sv | 24 ++
 rtl/spi_ctrl_regfile.sv | 74 +++++++
 rtl/spi_cmd_ctrl.sv | 122 ++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command controller.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RLOAD = 2'd2,
    RPUSH = 2'd3
  } state_e;

  localparam logic [7:0]  ADDR_CTRL      = 8'h70;
  localparam logic [7:0]  ADDR_STATUS    = 8'h71;
  localparam logic [7:0]  ADDR_ID        = 8'h72;
  localparam logic [15:0] READ_DEFAULT   = 16'hDEAD;
  localparam int          TX_HOLD_CYCLES = 2;

endpackage

// File: rtl/spi_ctrl_regfile.sv
// Config registers, CTRL/STATUS decode, done/err flags and the read mux.
module spi_ctrl_regfile
  import spi_ctrl_pkg::*;
#(
  parameter int                   DATA_SIZE = 16,
  parameter int                   NUM_REGS  = 8,
  parameter logic [DATA_SIZE-1:0] ID_VALUE  = 16'hA5C3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_addr_i,
  input  logic [DATA_SIZE-1:0]          wr_data_i,
  input  logic [7:0]                    rd_addr_i,
  output logic [DATA_SIZE-1:0]          rd_data_o,
  input  logic                          err_set_i,
  input  logic                          acc_busy_i,
  input  logic                          acc_done_i,
  output logic [NUM_REGS*DATA_SIZE-1:0] cfg_regs_o,
  output logic                          acc_start_o
);

  logic [NUM_REGS*DATA_SIZE-1:0] cfg_q;
  logic done_q, done_d;
  logic err_q, err_d;
  logic acc_start_q;
  logic ctrl_wr, cfg_hit, bad_wr;

  always_comb begin
    ctrl_wr = wr_en_i && (wr_addr_i == ADDR_CTRL);
    cfg_hit = int'(wr_addr_i) < NUM_REGS;
    bad_wr  = wr_en_i && !cfg_hit && !ctrl_wr;
    // Set has priority over clear for both flags.
    done_d = done_q;
    if (ctrl_wr && (wr_data_i[0] || wr_data_i[1])) done_d = 1'b0;
    if (acc_done_i) done_d = 1'b1;
    err_d = err_q;
    if (ctrl_wr && wr_data_i[1]) err_d = 1'b0;
    if (err_set_i || bad_wr) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_start_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_i && (wr_addr_i == 8'(i))) cfg_q[i*DATA_SIZE +: DATA_SIZE] <= wr_data_i;
      end
      done_q      <= done_d;
      err_q       <= err_d;
      acc_start_q <= ctrl_wr && wr_data_i[0];
    end
  end

  always_comb begin
    rd_data_o = DATA_SIZE'(READ_DEFAULT);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_i == 8'(i)) rd_data_o = cfg_q[i*DATA_SIZE +: DATA_SIZE];
    end
    case (rd_addr_i)
      ADDR_CTRL:   rd_data_o = '0;
      ADDR_STATUS: rd_data_o = {{(DATA_SIZE-3){1'b0}}, err_q, done_q, acc_busy_i};
      ADDR_ID:     rd_data_o = ID_VALUE;
      default:     ;
    endcase
  end

  assign cfg_regs_o  = cfg_q;
  assign acc_start_o = acc_start_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes SPI frames into register read/write commands and sequences read
// responses into the SPI slave's transmit register.
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int                   DATA_SIZE = 16,
  parameter int                   NUM_REGS  = 8,
  parameter logic [DATA_SIZE-1:0] ID_VALUE  = 16'hA5C3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          rx_valid,
  input  logic [DATA_SIZE-1:0]          rx_data,
  input  logic                          tx_ready,
  output logic                          tx_valid,
  output logic [DATA_SIZE-1:0]          tx_data,
  output logic [NUM_REGS*DATA_SIZE-1:0] cfg_regs,
  output logic                          acc_start,
  input  logic                          acc_busy,
  input  logic                          acc_done
);

  logic                 cs_meta_q, cs_sync_q;
  logic                 rx_valid_q;
  state_e               state_q;
  logic                 tx_valid_q;
  logic [DATA_SIZE-1:0] tx_data_q;
  logic [1:0]           hold_cnt_q;
  logic [7:0]           waddr_q;

  logic                 frame;
  op_e                  op;
  logic                 wr_en;
  logic                 err_cmd;
  logic [DATA_SIZE-1:0] rd_data;

  // A frame is the rising edge of rx_valid; its idle-high level never counts.
  assign frame   = rx_valid && !rx_valid_q;
  assign op      = op_e'(rx_data[DATA_SIZE-1 -: 2]);
  assign wr_en   = frame && (state_q == WDATA) && !cs_sync_q;
  assign err_cmd = frame && (((state_q == IDLE) && (op == OP_RSVD)) ||
                             (state_q == RLOAD) || (state_q == RPUSH));

  spi_ctrl_regfile #(
    .DATA_SIZE (DATA_SIZE),
    .NUM_REGS  (NUM_REGS),
    .ID_VALUE  (ID_VALUE)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (waddr_q),
    .wr_data_i   (rx_data),
    .rd_addr_i   (rx_data[7:0]),
    .rd_data_o   (rd_data),
    .err_set_i   (err_cmd),
    .acc_busy_i  (acc_busy),
    .acc_done_i  (acc_done),
    .cfg_regs_o  (cfg_regs),
    .acc_start_o (acc_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      rx_valid_q <= 1'b1;
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      hold_cnt_q <= '0;
      waddr_q    <= '0;
    end else begin
      cs_meta_q  <= cs;
      cs_sync_q  <= cs_meta_q;
      rx_valid_q <= rx_valid;
      case (state_q)
        IDLE: begin
          if (frame) begin
            case (op)
              OP_WRITE: begin
                waddr_q <= rx_data[7:0];
                state_q <= WDATA;
              end
              OP_READ: begin
                tx_data_q <= rd_data;
                state_q   <= RLOAD;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        WDATA: begin
          if (cs_sync_q || frame) state_q <= IDLE;
        end
        RLOAD: begin
          if (cs_sync_q) begin
            state_q <= IDLE;
          end else if (tx_ready) begin
            tx_valid_q <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= RPUSH;
          end
        end
        RPUSH: begin
          if (cs_sync_q || (hold_cnt_q == 2'(TX_HOLD_CYCLES - 1))) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed, table-driven bench for spi_cmd_ctrl.
module tb_spi_cmd_ctrl;

  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst, cs, rx_valid, tx_ready, acc_busy, acc_done;
  logic [15:0]   rx_data;
  logic          tx_valid, acc_start;
  logic [15:0]   tx_data;
  logic [NR*16-1:0] cfg_regs;

  int total = 0;
  int bad   = 0;
  logic [15:0] model [NR];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rexp;
    logic        err;
  } vec_t;
  vec_t vt [9];

  spi_cmd_ctrl #(.DATA_SIZE(16), .NUM_REGS(NR), .ID_VALUE(16'hA5C3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .cfg_regs  (cfg_regs),
    .acc_start (acc_start),
    .acc_busy  (acc_busy),
    .acc_done  (acc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*16 +: 16] = model[i];
    return f;
  endfunction

  // Returns at the falling edge one cycle after the frame was detected.
  task automatic send_frame(input logic [15:0] w);
    @(negedge clk);
    rx_data  = w;
    rx_valid = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    send_frame({8'h80, a});
    send_frame(d);
    if (int'(a) < NR) model[a] = d;
  endtask

  task automatic do_read(input logic [15:0] cmd, output logic [15:0] d, output int n);
    send_frame(cmd);
    n = 0;
    d = tx_data;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid) begin
        n++;
        if (tx_data !== d) d = 16'hxxxx;
      end
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    int n;

    vt[0] = '{8'h03, 16'h1234, 16'h1234, 1'b0};
    vt[1] = '{8'h00, 16'hFFFF, 16'hFFFF, 1'b0};
    vt[2] = '{8'h07, 16'h8001, 16'h8001, 1'b0};
    vt[3] = '{8'h01, 16'h00A5, 16'h00A5, 1'b0};
    vt[4] = '{8'h72, 16'h1111, 16'hA5C3, 1'b1};
    vt[5] = '{8'h71, 16'hFFFF, 16'h0004, 1'b1};
    vt[6] = '{8'h70, 16'h0000, 16'h0000, 1'b0};
    vt[7] = '{8'h40, 16'h7777, 16'hDEAD, 1'b1};
    vt[8] = '{8'h08, 16'h2222, 16'hDEAD, 1'b1};

    rst = 1'b1; cs = 1'b0; rx_valid = 1'b1; rx_data = '0;
    tx_ready = 1'b1; acc_busy = 1'b0; acc_done = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("reset_tx_valid", 128'(tx_valid), 128'd0);
    chk("reset_tx_data", 128'(tx_data), 128'd0);
    chk("reset_cfg", cfg_regs, 128'd0);
    chk("reset_acc_start", 128'(acc_start), 128'd0);
    do_read(16'h4071, d, n);
    chk("reset_status", 128'(d), 128'h0000);

    // Write, read back, then check the err flag through STATUS.
    for (int k = 0; k < 9; k++) begin
      wr(8'h70, 16'h0002);
      wr(vt[k].addr, vt[k].wdata);
      chk($sformatf("tbl%0d_cfg", k), cfg_regs, flat());
      do_read({8'h40, vt[k].addr}, d, n);
      chk($sformatf("tbl%0d_rdata", k), 128'(d), 128'(vt[k].rexp));
      chk($sformatf("tbl%0d_txv_cycles", k), 128'(n), 128'd2);
      do_read(16'h4071, d, n);
      chk($sformatf("tbl%0d_status", k), 128'(d), 128'({vt[k].err, 2'b00}));
    end

    // Start pulse and done/err flag behaviour.
    wr(8'h70, 16'h0002);
    wr(8'h70, 16'h0001);
    chk("start_pulse_hi", 128'(acc_start), 128'd1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (acc_start) n++;
    end
    chk("start_pulse_lo", 128'(n), 128'd0);
    pulse_done();
    do_read(16'h4071, d, n);
    chk("done_set", 128'(d), 128'h0002);
    wr(8'h70, 16'h0001);
    do_read(16'h4071, d, n);
    chk("done_clr_bit0", 128'(d), 128'h0000);
    pulse_done();
    send_frame(16'h8070);
    @(negedge clk);
    rx_data  = 16'h0002;
    rx_valid = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    do_read(16'h4071, d, n);
    chk("done_set_wins", 128'(d), 128'h0002);
    wr(8'h70, 16'h0002);
    do_read(16'h4071, d, n);
    chk("done_clr_bit1", 128'(d), 128'h0000);
    acc_busy = 1'b1;
    do_read(16'h4071, d, n);
    chk("status_busy", 128'(d), 128'h0001);
    acc_busy = 1'b0;
    send_frame(16'hC012);
    do_read(16'h4071, d, n);
    chk("rsvd_err", 128'(d), 128'h0004);

    // cs deassertion between write command and data word.
    send_frame(16'h8002);
    @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    do_read(16'h5555, d, n);
    chk("cs_abort_rdata", 128'(d), 128'hDEAD);
    chk("cs_abort_txv_cycles", 128'(n), 128'd2);
    chk("cs_abort_cfg", cfg_regs, flat());

    // tx_ready stall, ignored frame in RLOAD, reset during RPUSH.
    tx_ready = 1'b0;
    send_frame(16'h4001);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) n++;
    end
    chk("stall_txv", 128'(n), 128'd0);
    send_frame(16'h8001);
    chk("ignored_frame_cfg", cfg_regs, flat());
    tx_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_txv", 128'(tx_valid), 128'd1);
    chk("stall_release_data", 128'(tx_data), 128'(model[1]));
    rst = 1'b1;
    #1;
    chk("rst_txv", 128'(tx_valid), 128'd0);
    chk("rst_cfg", cfg_regs, 128'd0);
    chk("rst_tx_data", 128'(tx_data), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (4) @(negedge clk);
    wr(8'h04, 16'h00BB);
    chk("post_rst_cfg", cfg_regs, flat());
    do_read(16'h4004, d, n);
    chk("post_rst_rdata", 128'(d), 128'h00BB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
